// File: rtl/gpio_port_if.sv
// gpio_port_if: CPU data-bus view of the gpio_port register file.
// The CPU side drives address, strobes and write data; the port returns
// registered read data one cycle after a read strobe.
interface gpio_port_if #(
  parameter int DATA_WIDTH = 16
);
  logic [1:0]            addr;
  logic                  we;
  logic                  re;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output addr,
    output we,
    output re,
    output wdata,
    input  rdata
  );

  modport slave (
    input  addr,
    input  we,
    input  re,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/gpio_port.sv
// gpio_port: parametrised memory-mapped switch/LED port.
// Raw switches are synchronised, then debounced per bit. Any change of the
// debounced value latches a per-bit EDGE flag (write-1-to-clear). The
// interrupt is the registered OR of pending, enabled EDGE flags.
// Register map: 0 SW (ro), 1 LED (rw), 2 EDGE (w1c), 3 MASK (rw).
// Bits above the implemented width read as 0 and ignore writes.
module gpio_port #(
  parameter int DATA_WIDTH      = 16,
  parameter int SW_WIDTH        = 16,
  parameter int LED_WIDTH       = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  gpio_port_if.slave           bus,
  input  logic [SW_WIDTH-1:0]  switches,
  output logic [LED_WIDTH-1:0] leds,
  output logic                 irq
);

  localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
  // Counter value on the edge that completes a stable run; the new
  // value is accepted on that same edge instead of counting further.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  localparam logic [1:0] ADDR_SW   = 2'd0;
  localparam logic [1:0] ADDR_LED  = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;
  localparam logic [1:0] ADDR_MASK = 2'd3;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [SW_WIDTH-1:0]   sync_r [SYNC_STAGES];
  logic [CNT_WIDTH-1:0]  cnt_r  [SW_WIDTH];
  logic [SW_WIDTH-1:0]   sw_db_r;
  logic [SW_WIDTH-1:0]   edge_r;
  logic [SW_WIDTH-1:0]   mask_r;
  logic [LED_WIDTH-1:0]  leds_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic                  irq_r;

  // ---------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------
  logic [SW_WIDTH-1:0]   sw_s;
  logic [SW_WIDTH-1:0]   db_accept_s;
  logic                  wr_led_s;
  logic                  wr_edge_s;
  logic                  wr_mask_s;
  logic [SW_WIDTH-1:0]   edge_clr_s;
  logic [DATA_WIDTH-1:0] rd_sel_s;

  assign sw_s = sync_r[SYNC_STAGES-1];

  // Shift raw switches through the synchroniser chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= '0;
      end
    end else begin
      sync_r[0] <= switches;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  // Flag the bits whose disagreeing sample completes a full stable run.
  always_comb begin
    db_accept_s = '0;
    for (int i = 0; i < SW_WIDTH; i++) begin
      if ((sw_s[i] != sw_db_r[i]) && (cnt_r[i] == CNT_LAST)) begin
        db_accept_s[i] = 1'b1;
      end else begin
        db_accept_s[i] = 1'b0;
      end
    end
  end

  // Per-bit debounce counters: count disagreeing samples, clear on agreement or acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SW_WIDTH; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SW_WIDTH; i++) begin
        if ((sw_s[i] == sw_db_r[i]) || db_accept_s[i]) begin
          cnt_r[i] <= '0;
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_ONE;
        end
      end
    end
  end

  // Debounced switch value: an accepted bit always flips, since it differed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_db_r <= '0;
    end else begin
      sw_db_r <= sw_db_r ^ db_accept_s;
    end
  end

  // Decode bus writes into per-register strobes and the EDGE clear vector.
  always_comb begin
    wr_led_s   = 1'b0;
    wr_edge_s  = 1'b0;
    wr_mask_s  = 1'b0;
    edge_clr_s = '0;
    if (bus.we) begin
      case (bus.addr)
        ADDR_SW: begin
          wr_led_s  = 1'b0;
        end
        ADDR_LED: begin
          wr_led_s  = 1'b1;
        end
        ADDR_EDGE: begin
          wr_edge_s = 1'b1;
        end
        ADDR_MASK: begin
          wr_mask_s = 1'b1;
        end
        default: begin
          wr_led_s  = 1'b0;
        end
      endcase
    end else begin
      wr_led_s = 1'b0;
    end
    if (wr_edge_s) begin
      edge_clr_s = bus.wdata[SW_WIDTH-1:0];
    end else begin
      edge_clr_s = '0;
    end
  end

  // LED register, written from the low LED_WIDTH bits of the bus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      leds_r <= '0;
    end else if (wr_led_s) begin
      leds_r <= bus.wdata[LED_WIDTH-1:0];
    end
  end

  // EDGE flags: write-1-to-clear, but a same-cycle set takes priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      edge_r <= '0;
    end else begin
      edge_r <= (edge_r & ~edge_clr_s) | db_accept_s;
    end
  end

  // Interrupt enable mask.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_r <= '0;
    end else if (wr_mask_s) begin
      mask_r <= bus.wdata[SW_WIDTH-1:0];
    end
  end

  // Interrupt request from currently pending and enabled EDGE flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= |(edge_r & mask_r);
    end
  end

  // Read mux over the pre-write register contents, zero-extended to the bus.
  always_comb begin
    rd_sel_s = '0;
    case (bus.addr)
      ADDR_SW: begin
        rd_sel_s[SW_WIDTH-1:0] = sw_db_r;
      end
      ADDR_LED: begin
        rd_sel_s[LED_WIDTH-1:0] = leds_r;
      end
      ADDR_EDGE: begin
        rd_sel_s[SW_WIDTH-1:0] = edge_r;
      end
      ADDR_MASK: begin
        rd_sel_s[SW_WIDTH-1:0] = mask_r;
      end
      default: begin
        rd_sel_s = '0;
      end
    endcase
  end

  // Read data register: loads on a read strobe, otherwise holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_r <= '0;
    end else if (bus.re) begin
      rdata_r <= rd_sel_s;
    end
  end

  assign bus.rdata = rdata_r;
  assign leds      = leds_r;
  assign irq       = irq_r;

endmodule
